// File: rtl/q_seq_bin_div.sv
// Sequential restoring divider: one quotient bit per shift/subtract state pair.
// The start/rdy handshake and the state layout match the shift-add multiplier.
`timescale 1ns/1ps
module q_seq_bin_div #(
  parameter int DP_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DP_WIDTH-1:0] dividend,
  input  logic [DP_WIDTH-1:0] divisor,
  output logic [DP_WIDTH-1:0] quotient,
  output logic [DP_WIDTH-1:0] remainder,
  output logic                rdy,
  output logic                div_by_zero
);

  localparam int BC_SIZE = $clog2(DP_WIDTH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_SUB   = 2'd2;

  // Handshake: start is taken at a rising edge only while rdy=1. rdy falls
  // after that edge and rises again once quotient/remainder are final; the
  // results then hold until the next accepted start or reset.
  logic [1:0]          state;
  logic [DP_WIDTH:0]   a;
  logic [DP_WIDTH-1:0] q;
  logic [DP_WIDTH-1:0] b;
  logic [BC_SIZE-1:0]  p;

  logic [DP_WIDTH:0] b_ext;
  logic              a_ge_b;
  logic [DP_WIDTH:0] a_minus_b;

  // The compare and subtract are one bit wider than the operands, because the
  // shifted partial remainder can reach 2*B-1.
  assign b_ext     = {1'b0, b};
  assign a_ge_b    = (a >= b_ext);
  assign a_minus_b = a - b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      a           <= '0;
      q           <= '0;
      b           <= '0;
      p           <= BC_SIZE'(DP_WIDTH);
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              a           <= '0;
              q           <= dividend;
              b           <= divisor;
              p           <= BC_SIZE'(DP_WIDTH);
              div_by_zero <= 1'b0;
              state       <= S_SHIFT;
            end else begin
              // Divide by zero completes immediately with no busy cycle.
              div_by_zero <= 1'b1;
              q           <= '1;
              a           <= {1'b0, dividend};
            end
          end
        end
        S_SHIFT: begin
          a     <= {a[DP_WIDTH-1:0], q[DP_WIDTH-1]};
          q     <= {q[DP_WIDTH-2:0], 1'b0};
          p     <= p - BC_SIZE'(1);
          state <= S_SUB;
        end
        S_SUB: begin
          if (a_ge_b) begin
            a    <= a_minus_b;
            q[0] <= 1'b1;
          end else begin
            q[0] <= 1'b0;
          end
          state <= (p == '0) ? S_IDLE : S_SHIFT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign quotient  = q;
  assign remainder = a[DP_WIDTH-1:0];
  assign rdy       = (state == S_IDLE);

endmodule

// File: tb/tb_q_seq_bin_div.sv
// Directed bench for q_seq_bin_div at DP_WIDTH=8, plus a full 4-bit sweep on a
// second instance at DP_WIDTH=4.
`timescale 1ns/1ps
module tb_q_seq_bin_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor, quotient, remainder;
  logic       rdy, div_by_zero;

  logic       start4;
  logic [3:0] dividend4, divisor4, quotient4, remainder4;
  logic       rdy4, div_by_zero4;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  q_seq_bin_div #(.DP_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .rdy(rdy), .div_by_zero(div_by_zero)
  );

  q_seq_bin_div #(.DP_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .dividend(dividend4), .divisor(divisor4),
    .quotient(quotient4), .remainder(remainder4), .rdy(rdy4), .div_by_zero(div_by_zero4)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for rdy (bounded); returns number of edges waited.
  task automatic wait_rdy(output int cycles);
    cycles = 0;
    while (!rdy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  task automatic do_op(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                       input logic [7:0] exp_q, input logic [7:0] exp_r);
    int cyc;
    wait_rdy(cyc);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_rdy(cyc);
    check({tag, " busy"}, cyc, 16);
    check({tag, " quot"}, quotient, exp_q);
    check({tag, " rem"},  remainder, exp_r);
    check({tag, " dbz"},  div_by_zero, 0);
  endtask

  task automatic do_op4(input logic [3:0] dd, input logic [3:0] dv);
    int cyc;
    logic [3:0] eq, er;
    dividend4 = dd;
    divisor4  = dv;
    start4    = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 0;
    while (!rdy4 && cyc < 100) begin
      tick();
      cyc++;
    end
    if (dv == 4'd0) begin
      eq = 4'hF;
      er = dd;
    end else begin
      eq = dd / dv;
      er = dd % dv;
    end
    check("w4 busy", cyc, (dv == 4'd0) ? 0 : 8);
    check("w4 quot", quotient4, eq);
    check("w4 rem",  remainder4, er);
    check("w4 dbz",  div_by_zero4, (dv == 4'd0) ? 1 : 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    start4 = 1'b0; dividend4 = '0; divisor4 = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset rdy",  rdy, 1);
    check("reset quot", quotient, 0);
    check("reset rem",  remainder, 0);
    check("reset dbz",  div_by_zero, 0);

    // 1. basic
    do_op("200/7", 8'd200, 8'd7, 8'd28, 8'd4);

    // 2. edge operands
    do_op("255/1",   8'd255, 8'd1,   8'd255, 8'd0);
    do_op("255/255", 8'd255, 8'd255, 8'd1,   8'd0);
    do_op("5/9",     8'd5,   8'd9,   8'd0,   8'd5);
    do_op("0/13",    8'd0,   8'd13,  8'd0,   8'd0);

    // 3. divide by zero, then recovery
    dividend = 8'd77; divisor = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("77/0 rdy",  rdy, 1);
    check("77/0 dbz",  div_by_zero, 1);
    check("77/0 quot", quotient, 255);
    check("77/0 rem",  remainder, 77);
    tick();
    check("77/0 hold", quotient, 255);
    do_op("9/3", 8'd9, 8'd3, 8'd3, 8'd0);

    // 4a. start pulsed while busy is ignored
    dividend = 8'd100; divisor = 8'd10; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    dividend = 8'd50; divisor = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy start rdy", rdy, 0);
    wait_rdy(cyc);
    check("100/10 busy", cyc, 11);
    check("100/10 quot", quotient, 10);
    check("100/10 rem",  remainder, 0);

    // 4b. start held high: back-to-back runs with a one-edge rdy pulse
    dividend = 8'd81; divisor = 8'd4; start = 1'b1;
    tick();
    for (int run = 0; run < 2; run++) begin
      wait_rdy(cyc);
      check("81/4 busy", cyc, 16);
      check("81/4 quot", quotient, 20);
      check("81/4 rem",  remainder, 1);
      tick();
      check("81/4 reaccept", rdy, 0);
    end
    start = 1'b0;
    wait_rdy(cyc);

    // 5. reset mid-operation
    dividend = 8'd123; divisor = 8'd11; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    check("pre-rst busy", rdy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid rst rdy",  rdy, 1);
    check("mid rst quot", quotient, 0);
    check("mid rst rem",  remainder, 0);
    do_op("123/11", 8'd123, 8'd11, 8'd11, 8'd2);

    // 6a. random operands against a / and % model
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(1, 255));
      do_op("rand", ra, rb, ra / rb, ra % rb);
    end

    // 6b. exhaustive 4-bit sweep, divisor 0 included
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        do_op4(4'(x), 4'(y));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
